adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin arbiter that shares one combinational adder between N_REQ
//   requesters. Each requester presents an operand pair. The granted pair
//   goes to the adder, and the sum is captured in a single-entry result
//   register. A new grant can be issued in the same cycle that the held
//   result is drained, so throughput is one operation per cycle.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   req_valid  per-requester operand-pair valid
//   req_a/b    packed operands; requester i uses [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant, or zero (combinational)
//   add_a/b    operands to the shared adder; zero when no grant
//   add_sum    combinational sum returned by the shared adder
//   rsp_valid  the result register holds a valid result
//   rsp_id     index of the requester that owns the result
//   rsp_sum    registered sum
//   rsp_ready  the consumer accepts the result this cycle
//   op_count   number of granted operations; saturates at 16'hFFFF
//
// state | meaning
// EMPTY | no result held; a grant is always allowed
// FULL  | result held; a grant is allowed only while it drains (rsp_ready=1)

module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic [WIDTH-1:0]           add_sum,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  input  logic                       rsp_ready,
  output logic [15:0]                op_count
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic            grant_ok;
  logic            grant;
  logic [ID_W-1:0] grant_idx;
  int              cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_ok  = 1'b0;
    grant     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;

    // The rst_n term keeps req_ready low for as long as reset is held.
    grant_ok = rst_n && ((state == EMPTY) || rsp_ready);

    // The search starts just after the last winner and wraps around.
    // The first valid requester found wins.
    if (grant_ok) begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = (int'(last_grant) + off) % N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
          if (!grant && (i == cand) && req_valid[i]) begin
            grant     = 1'b1;
            grant_idx = ID_W'(i);
          end
        end
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (grant && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[i*WIDTH +: WIDTH];
        add_b        = req_b[i*WIDTH +: WIDTH];
      end
    end

    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (grant)          state_nxt = FULL;
               else if (rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_REQ - 1);
      rsp_sum    <= '0;
      rsp_id     <= '0;
      op_count   <= '0;
    end else if (grant) begin
      last_grant <= grant_idx;
      rsp_sum    <= add_sum;
      rsp_id     <= grant_idx;
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule
